// File: rtl/lab2_proc_div_pkg.sv
// Shared types and constants for the lab2 iterative integer divide unit.
package lab2_proc_div_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FN_W   = 2;
  localparam int unsigned MSG_W  = FN_W + 2 * DATA_W;
  localparam int unsigned CNT_W  = 5;

  // req_msg layout: {fn, a, b}
  localparam int unsigned B_LSB  = 0;
  localparam int unsigned A_LSB  = DATA_W;
  localparam int unsigned FN_LSB = 2 * DATA_W;

  typedef enum logic [FN_W-1:0] {
    FN_DIV  = 2'd0,
    FN_DIVU = 2'd1,
    FN_REM  = 2'd2,
    FN_REMU = 2'd3
  } fn_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    fn_t               fn;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_msg_t;

  function automatic logic is_signed_fn(input fn_t fn);
    return (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic             signed_op);
    return (signed_op && x[DATA_W-1]) ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/lab2_proc_int_div_unit_if.sv
// Request/response val/rdy bundle between the X stage and the divide unit.
interface lab2_proc_int_div_unit_if;

  logic                                      req_val;
  logic                                      req_rdy;
  lab2_proc_div_pkg::req_msg_t               req_msg;
  logic                                      resp_val;
  logic                                      resp_rdy;
  logic [lab2_proc_div_pkg::DATA_W-1:0]      resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/lab2_proc_IntDivUnitDpath.sv
// Divider datapath: operand magnitudes, restoring shift-subtract step,
// iteration counter and sign/divide-by-zero correction into a result register.
module lab2_proc_IntDivUnitDpath
  import lab2_proc_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  req_msg_t          req,
  output logic              last_iter,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned REM_W = DATA_W + 1;

  fn_t               fn_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] quo_q;
  logic [REM_W-1:0]  rem_q;
  logic [DATA_W-1:0] result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sign_q_q;
  logic              sign_r_q;
  logic              dz_q;

  logic              req_signed;
  logic [REM_W-1:0]  rem_sh;
  logic [REM_W:0]    diff;
  logic              ge;
  logic [REM_W-1:0]  rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] result_nxt;

  assign req_signed = is_signed_fn(req.fn);
  assign last_iter  = (cnt_q == CNT_W'(DATA_W - 1));
  assign result     = result_q;

  // One restoring step; rem_q[32] is zero in practice but still forces a subtract.
  always_comb begin
    rem_sh  = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    diff    = {1'b0, rem_sh} - {2'b00, divisor_q};
    ge      = ~diff[REM_W] | rem_q[DATA_W];
    rem_nxt = ge ? diff[REM_W-1:0] : rem_sh;
    quo_nxt = {quo_q[DATA_W-2:0], ge};
  end

  // Correction applied to the final step's values so the result can be registered.
  always_comb begin
    quo_fix    = dz_q ? '1 : (sign_q_q ? DATA_W'(-quo_nxt) : quo_nxt);
    rem_fix    = sign_r_q ? DATA_W'(-rem_nxt[DATA_W-1:0]) : rem_nxt[DATA_W-1:0];
    result_nxt = ((fn_q == FN_REM) || (fn_q == FN_REMU)) ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q      <= FN_DIV;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      dz_q      <= 1'b0;
    end else if (load) begin
      fn_q      <= req.fn;
      divisor_q <= magnitude(req.b, req_signed);
      quo_q     <= magnitude(req.a, req_signed);
      rem_q     <= '0;
      cnt_q     <= '0;
      sign_q_q  <= req_signed & (req.a[DATA_W-1] ^ req.b[DATA_W-1]);
      sign_r_q  <= req_signed & req.a[DATA_W-1];
      dz_q      <= (req.b == '0);
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        result_q <= result_nxt;
      end
    end
  end

endmodule

// File: rtl/lab2_proc_int_div_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit: control FSM and val/rdy handshakes
// around the shift-subtract datapath.
module lab2_proc_int_div_unit
  import lab2_proc_div_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  lab2_proc_int_div_unit_if.slave  io
);

  state_t            state_q;
  logic              req_rdy_q;
  logic              resp_val_q;
  logic              load;
  logic              step;
  logic              last_iter;
  logic [DATA_W-1:0] result;

  assign load = (state_q == ST_IDLE) && io.req_val;
  assign step = (state_q == ST_CALC);

  assign io.req_rdy  = req_rdy_q;
  assign io.resp_val = resp_val_q;
  assign io.resp_msg = result;

  lab2_proc_IntDivUnitDpath u_dpath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .req       (io.req_msg),
    .last_iter (last_iter),
    .result    (result)
  );

  // Handshake flags are registered alongside the state so outputs depend on state only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.req_val) begin
            state_q   <= ST_CALC;
            req_rdy_q <= 1'b0;
          end
        end
        ST_CALC: begin
          if (last_iter) begin
            state_q    <= ST_DONE;
            resp_val_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (io.resp_rdy) begin
            state_q    <= ST_IDLE;
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          req_rdy_q  <= 1'b1;
          resp_val_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_proc_int_div_unit.sv
// Self-checking bench for lab2_proc_int_div_unit: directed RISC-V corner cases,
// backpressure, mid-operation reset and randomized operations against a model.
module tb_lab2_proc_int_div_unit;
  import lab2_proc_div_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  lab2_proc_int_div_unit_if bus ();

  lab2_proc_int_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V divide semantics in plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Transaction-level model: busy flag, response due cycle and expected value.
  int          cyc = 0;
  bit          busy = 0;
  int          done_at = 0;
  logic [31:0] exp_res = '0;

  always @(posedge clk) begin : model
    bit was_done;
    was_done = busy && (cyc >= done_at);
    cyc++;
    if (reset) begin
      busy = 0;
    end else if (!busy) begin
      if (bus.req_val) begin
        busy    = 1;
        done_at = cyc + 32;
        exp_res = ref_res(bus.req_msg.fn, bus.req_msg.a, bus.req_msg.b);
      end
    end else if (was_done && bus.resp_rdy) begin
      busy = 0;
    end
  end

  always @(negedge clk) begin : compare
    bit exp_val;
    if (chk_en) begin
      exp_val = busy && (cyc >= done_at);
      chk("req_rdy", 32'(bus.req_rdy), 32'(!busy));
      chk("resp_val", 32'(bus.resp_val), 32'(exp_val));
      if (exp_val) chk("resp_msg", bus.resp_msg, exp_res);
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold,
                        input bit poke);
    int          k;
    logic [31:0] got;
    wait_idle();
    bus.resp_rdy = (hold == 0);
    bus.req_msg  = '{fn: fn_t'(f), a: a, b: b};
    bus.req_val  = 1'b1;
    @(posedge clk); #1;
    bus.req_val  = 1'b0;
    bus.req_msg  = '{fn: fn_t'($urandom_range(0, 3)), a: $urandom, b: $urandom};
    k = 1;
    while (!bus.resp_val && k < 100) begin
      bus.req_val = poke && (k == 10);
      @(posedge clk); #1;
      k++;
    end
    bus.req_val = 1'b0;
    chk({name, "_latency"}, 32'(k), 32'd33);
    got = bus.resp_msg;
    chk(name, got, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, "_stable"}, bus.resp_msg, got);
      chk({name, "_hold_rdy"}, 32'(bus.req_rdy), 32'd0);
    end
    bus.resp_rdy = 1'b1;
    @(posedge clk); #1;
    chk({name, "_idle"}, 32'(bus.req_rdy), 32'd1);
  endtask

  task automatic dir_op(input string name, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    chk({"model_", name}, ref_res(f, a, b), exp);
    run_op(name, f, a, b, exp, 0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    reset        = 1'b1;
    bus.req_val  = 1'b0;
    bus.resp_rdy = 1'b1;
    bus.req_msg  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    chk("rst_resp_val", 32'(bus.resp_val), 32'd0);
    chk("rst_resp_msg", bus.resp_msg, 32'd0);
    chk_en = 1;
    reset  = 1'b0;

    dir_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14);
    dir_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2);
    dir_op("div_m7_2", 2'd0, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    dir_op("rem_m7_2", 2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    dir_op("div_7_m2", 2'd0, 32'd7, -32'sd2, 32'hFFFF_FFFD);
    dir_op("rem_7_m2", 2'd2, 32'd7, -32'sd2, 32'd1);
    dir_op("div_5_0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);
    dir_op("divu_5_0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF);
    dir_op("rem_m5_0", 2'd2, -32'sd5, 32'd0, 32'hFFFF_FFFB);
    dir_op("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5);
    dir_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    dir_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    dir_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    // Backpressure with a request pulse during CALC.
    run_op("bp_divu", 2'd1, 32'd1000, 32'd7, 32'd142, 10, 1'b1);

    // Reset at iteration 15 drops the operation.
    wait_idle();
    bus.resp_rdy = 1'b1;
    bus.req_msg  = '{fn: FN_DIVU, a: 32'd1000, b: 32'd3};
    bus.req_val  = 1'b1;
    @(posedge clk); #1;
    bus.req_val  = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_req_rdy", 32'(bus.req_rdy), 32'd1);
    chk("midrst_resp_val", 32'(bus.resp_val), 32'd0);
    dir_op("after_rst_divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3);

    for (int i = 0; i < 150; i++) begin
      f = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op("rand", f, a, b, ref_res(f, a, b), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
